// File: rtl/mmio_timer_if.sv
// Data-memory-port bus as seen by a memory-mapped responder.
interface mmio_timer_if;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic        hit;
  logic        irq;

  modport master (output a, output wd, output we, input rd, input hit, input irq);
  modport slave  (input a, input wd, input we, output rd, output hit, output irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer/counter with compare, wrap and level interrupt.
module mmio_timer #(
  parameter logic [31:0] BASE = 32'h0000_0080
) (
  input  logic         clk,
  input  logic         reset_n,
  mmio_timer_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 8;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic          en, reload, ien;
  logic [PW-1:0] presc;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] count;
  logic [DW-1:0] cmp;
  logic          match, wrap;

  logic          hit_c;
  logic [1:0]    off_c;
  logic          wr_ctrl_c, wr_count_c, wr_cmp_c, wr_status_c;
  logic          tick_c;
  logic          cnt_eq_cmp_c, cnt_max_c;
  logic          set_match_c, set_wrap_c;
  logic          clr_match_c, clr_wrap_c;
  logic [DW-1:0] rd_c;
  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = bus.a[1:0];

  // Address decode and write strobes
  assign hit_c       = (bus.a[31:4] == BASE[31:4]);
  assign off_c       = bus.a[3:2];
  assign wr_ctrl_c   = bus.we & hit_c & (off_c == OFF_CTRL);
  assign wr_count_c  = bus.we & hit_c & (off_c == OFF_COUNT);
  assign wr_cmp_c    = bus.we & hit_c & (off_c == OFF_CMP);
  assign wr_status_c = bus.we & hit_c & (off_c == OFF_STATUS);

  // Tick and event detection use the pre-edge CTRL/CMP values
  assign tick_c       = en & (pcnt == presc);
  assign cnt_eq_cmp_c = (count == cmp);
  assign cnt_max_c    = (count == {DW{1'b1}});
  // A CPU write to COUNT overrides the tick and suppresses its events
  assign set_match_c  = tick_c & ~wr_count_c & cnt_eq_cmp_c;
  assign set_wrap_c   = tick_c & ~wr_count_c & ~cnt_eq_cmp_c & cnt_max_c;
  assign clr_match_c  = wr_status_c & bus.wd[0];
  assign clr_wrap_c   = wr_status_c & bus.wd[1];

  always_comb begin
    rd_c = '0;
    if (hit_c) begin
      case (off_c)
        OFF_CTRL:   rd_c = {16'b0, presc, 5'b0, ien, reload, en};
        OFF_COUNT:  rd_c = count;
        OFF_CMP:    rd_c = cmp;
        OFF_STATUS: rd_c = {30'b0, wrap, match};
        default:    rd_c = '0;
      endcase
    end
  end

  assign bus.rd  = rd_c;
  assign bus.hit = hit_c;
  assign bus.irq = ien & (match | wrap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      reload <= 1'b0;
      ien    <= 1'b0;
      presc  <= '0;
      pcnt   <= '0;
      count  <= '0;
      cmp    <= '0;
      match  <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        en     <= bus.wd[0];
        reload <= bus.wd[1];
        ien    <= bus.wd[2];
        presc  <= bus.wd[15:8];
      end

      // Any CTRL write restarts the prescaler
      if (wr_ctrl_c || !en || tick_c) pcnt <= '0;
      else                            pcnt <= pcnt + PW'(1);

      if (wr_count_c) begin
        count <= bus.wd;
      end else if (tick_c) begin
        if (cnt_eq_cmp_c && reload) count <= '0;
        else                        count <= count + DW'(1);
      end

      if (wr_cmp_c) cmp <= bus.wd;

      // Set has priority over write-1-to-clear
      match <= set_match_c | (match & ~clr_match_c);
      wrap  <= set_wrap_c  | (wrap  & ~clr_wrap_c);
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: decode, prescaler, match/reload, wrap, collisions.
module tb_mmio_timer;

  localparam logic [31:0] A_CTRL   = 32'h80;
  localparam logic [31:0] A_COUNT  = 32'h84;
  localparam logic [31:0] A_CMP    = 32'h88;
  localparam logic [31:0] A_STATUS = 32'h8C;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  mmio_timer_if bus ();

  mmio_timer #(.BASE(32'h0000_0080)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the store commits on the following rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.a  = addr;
    bus.wd = data;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.a  = addr;
    bus.we = 1'b0;
    #1;
    chk(tag, bus.rd, exp);
  endtask

  task automatic irqchk(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, bus.irq}, {31'b0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.a    = 32'h0;
    bus.wd   = 32'h0;
    bus.we   = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Reset state and decode
    rdchk("rst_ctrl", A_CTRL, 32'h0);
    rdchk("rst_count", A_COUNT, 32'h0);
    rdchk("rst_status", A_STATUS, 32'h0);
    irqchk("rst_irq", 1'b0);
    bus.a = 32'h84; #1;
    chk("hit_84", {31'b0, bus.hit}, 32'h1);
    chk("rd_84", bus.rd, 32'h0);
    bus.a = 32'h90; #1;
    chk("hit_90", {31'b0, bus.hit}, 32'h0);
    chk("rd_90", bus.rd, 32'h0);
    wr(32'h94, 32'h55);
    rdchk("oob_ctrl", A_CTRL, 32'h0);
    rdchk("oob_count", A_COUNT, 32'h0);
    rdchk("oob_cmp", A_CMP, 32'h0);

    // Prescaler: PRESC=3, tick every 4 cycles
    wr(A_CMP, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h0000_0301);
    rdchk("ctrl_rb", A_CTRL, 32'h0000_0301);
    idle(3);
    rdchk("presc_c0", A_COUNT, 32'd0);
    idle(1);
    rdchk("presc_c1", A_COUNT, 32'd1);
    idle(36);
    rdchk("presc_c10", A_COUNT, 32'd10);
    wr(A_CTRL, 32'h0);
    idle(8);
    rdchk("frozen", A_COUNT, 32'd10);

    // Match with reload: PRESC=0, CMP=5
    wr(A_COUNT, 32'h0);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h0000_0007);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      rdchk("reload_seq", A_COUNT, 32'(k));
    end
    rdchk("pre_match_status", A_STATUS, 32'h0);
    idle(1);
    rdchk("reload_zero", A_COUNT, 32'd0);
    rdchk("match_set", A_STATUS, 32'h1);
    irqchk("match_irq", 1'b1);
    idle(1);
    rdchk("reload_one", A_COUNT, 32'd1);
    wr(A_STATUS, 32'h1);
    rdchk("clr_status", A_STATUS, 32'h0);
    irqchk("clr_irq", 1'b0);
    idle(3);
    rdchk("pre_match2", A_COUNT, 32'd5);
    irqchk("pre_match2_irq", 1'b0);
    idle(1);
    rdchk("match2_status", A_STATUS, 32'h1);
    irqchk("match2_irq", 1'b1);

    // STATUS clear collides with MATCH set
    wr(A_STATUS, 32'h1);
    rdchk("clr_again", A_STATUS, 32'h0);
    idle(4);
    rdchk("coll_cnt5", A_COUNT, 32'd5);
    wr(A_STATUS, 32'h3);
    rdchk("coll_status", A_STATUS, 32'h1);
    irqchk("coll_irq", 1'b1);

    // COUNT write collides with a tick
    wr(A_COUNT, 32'h100);
    rdchk("cwr_tick", A_COUNT, 32'h100);
    idle(1);
    rdchk("cwr_next", A_COUNT, 32'h101);
    wr(A_COUNT, 32'd4);
    wr(A_STATUS, 32'h3);
    rdchk("cwr_cnt5", A_COUNT, 32'd5);
    rdchk("cwr_stat0", A_STATUS, 32'h0);
    wr(A_COUNT, 32'h100);
    rdchk("cwr_wins", A_COUNT, 32'h100);
    rdchk("cwr_nomatch", A_STATUS, 32'h0);
    wr(A_CTRL, 32'h0);

    // Wrap: COUNT near max, CMP=0, no reload
    wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'h0);
    wr(A_STATUS, 32'h3);
    wr(A_CTRL, 32'h0000_0005);
    idle(1);
    rdchk("wrap_max", A_COUNT, 32'hFFFF_FFFF);
    rdchk("wrap_pre_stat", A_STATUS, 32'h0);
    irqchk("wrap_pre_irq", 1'b0);
    idle(1);
    rdchk("wrap_zero", A_COUNT, 32'h0);
    rdchk("wrap_stat", A_STATUS, 32'h2);
    irqchk("wrap_irq", 1'b1);
    idle(1);
    rdchk("wrap_match_cnt", A_COUNT, 32'h1);
    rdchk("wrap_match_stat", A_STATUS, 32'h3);

    // Asynchronous reset mid-run with irq high
    reset_n = 1'b0;
    rdchk("mrst_ctrl", A_CTRL, 32'h0);
    rdchk("mrst_count", A_COUNT, 32'h0);
    rdchk("mrst_cmp", A_CMP, 32'h0);
    rdchk("mrst_status", A_STATUS, 32'h0);
    irqchk("mrst_irq", 1'b0);
    idle(2);
    rdchk("mrst_hold", A_COUNT, 32'h0);
    reset_n = 1'b1;
    idle(1);

    // CTRL rewrite mid-prescale restarts pcnt
    wr(A_CTRL, 32'h0000_0301);
    idle(2);
    wr(A_CTRL, 32'h0000_0301);
    rdchk("restart_c0", A_COUNT, 32'd0);
    idle(3);
    rdchk("restart_late", A_COUNT, 32'd0);
    idle(1);
    rdchk("restart_tick", A_COUNT, 32'd1);
    rdchk("restart_match", A_STATUS, 32'h1);
    irqchk("restart_noien", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
